// File: rtl/aui_pkg.sv
// Shared constants, block type and scheduler state encoding for the AUI
// transmit-path alignment-marker scheduler.
package aui_pkg;

  localparam int AUI_BITS_BLOCK  = 257;
  localparam int AUI_AM_BLOCKS   = 4;   // 1028 AM bits / 257 bits per block
  localparam int AUI_DATA_BLOCKS = 36;  // scrambled data blocks per AM period

  typedef logic [AUI_BITS_BLOCK-1:0] aui_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AM   = 2'd1,
    DATA = 2'd2
  } aui_sched_state_e;

endpackage : aui_pkg

// File: rtl/aui_out_stage.sv
// Single registered valid/ready output stage carrying one block pair plus
// the is_am / am_first tags. The caller asserts load only when load_ok is
// high; a load always wins over draining, so throughput is one block pair
// per cycle while m_ready stays high.
module aui_out_stage #(
  parameter int BITS_BLOCK = 257
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BITS_BLOCK-1:0] d_flow_0,
  input  logic [BITS_BLOCK-1:0] d_flow_1,
  input  logic                  d_is_am,
  input  logic                  d_am_first,
  input  logic                  m_ready,
  output logic                  load_ok,
  output logic                  m_valid,
  output logic [BITS_BLOCK-1:0] m_flow_0,
  output logic [BITS_BLOCK-1:0] m_flow_1,
  output logic                  m_is_am,
  output logic                  m_am_first
);

  logic                  valid_q,    valid_d;
  logic [BITS_BLOCK-1:0] flow_0_q,   flow_0_d;
  logic [BITS_BLOCK-1:0] flow_1_q,   flow_1_d;
  logic                  is_am_q,    is_am_d;
  logic                  am_first_q, am_first_d;

  // The register may take new data when empty or when its content leaves now.
  assign load_ok = !valid_q || m_ready;

  // Next-state: load new pair, else drop valid once accepted, else hold.
  always_comb begin
    valid_d    = valid_q;
    flow_0_d   = flow_0_q;
    flow_1_d   = flow_1_q;
    is_am_d    = is_am_q;
    am_first_d = am_first_q;
    if (load) begin
      valid_d    = 1'b1;
      flow_0_d   = d_flow_0;
      flow_1_d   = d_flow_1;
      is_am_d    = d_is_am;
      am_first_d = d_am_first;
    end else if (m_ready) begin
      valid_d    = 1'b0;
    end
  end

  // Output register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      flow_0_q   <= '0;
      flow_1_q   <= '0;
      is_am_q    <= 1'b0;
      am_first_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      flow_0_q   <= flow_0_d;
      flow_1_q   <= flow_1_d;
      is_am_q    <= is_am_d;
      am_first_q <= am_first_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_flow_0   = flow_0_q;
  assign m_flow_1   = flow_1_q;
  assign m_is_am    = is_am_q;
  assign m_am_first = am_first_q;

endmodule : aui_out_stage

// File: rtl/aui_am_scheduler.sv
// Alignment-marker scheduler for the two-flow AUI transmit block stream.
// Each period emits AM_BLOCKS marker blocks fetched by index from the AM
// generator, then DATA_BLOCKS upstream blocks; upstream is backpressured
// while markers are inserted.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready. Once m_valid is high, m_* stay stable until m_ready.
// s_ready does not depend on s_valid.
//
// Optional build macro AUI_AM_STATS_EN adds o_period_cnt (completed
// periods, wrapping) and o_underrun_cnt (saturating count of DATA cycles
// where a block could have been loaded but s_valid was low).
module aui_am_scheduler
  import aui_pkg::*;
#(
  parameter int BITS_BLOCK  = AUI_BITS_BLOCK,
  parameter int AM_BLOCKS   = AUI_AM_BLOCKS,
  parameter int DATA_BLOCKS = AUI_DATA_BLOCKS,
  parameter int CNT_W       = $clog2(DATA_BLOCKS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BITS_BLOCK-1:0]        s_flow_0,
  input  logic [BITS_BLOCK-1:0]        s_flow_1,
  output logic [$clog2(AM_BLOCKS)-1:0] o_am_idx,
  input  logic [BITS_BLOCK-1:0]        i_am_flow_0,
  input  logic [BITS_BLOCK-1:0]        i_am_flow_1,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [BITS_BLOCK-1:0]        m_flow_0,
  output logic [BITS_BLOCK-1:0]        m_flow_1,
  output logic                         m_is_am,
`ifdef AUI_AM_STATS_EN
  output logic                         m_am_first,
  output logic [31:0]                  o_period_cnt,
  output logic [15:0]                  o_underrun_cnt
`else
  output logic                         m_am_first
`endif
);

  localparam int IDX_W = $clog2(AM_BLOCKS);
  localparam logic [CNT_W-1:0] AM_LAST   = CNT_W'(AM_BLOCKS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BLOCKS - 1);

  aui_sched_state_e  state_q, state_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

  logic                  load_ok;
  logic                  load;
  logic                  sel_am;
  logic                  am_first;
  logic                  last_data_load;
  logic                  underrun;
  logic [IDX_W-1:0]      am_idx;
  logic [BITS_BLOCK-1:0] ld_flow_0;
  logic [BITS_BLOCK-1:0] ld_flow_1;

  // FSM next-state, block counter and load decision.
  always_comb begin
    state_d        = state_q;
    blk_cnt_d      = blk_cnt_q;
    s_ready        = 1'b0;
    am_idx         = '0;
    load           = 1'b0;
    sel_am         = 1'b0;
    am_first       = 1'b0;
    last_data_load = 1'b0;
    underrun       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d   = AM;
          blk_cnt_d = '0;
        end
      end
      AM: begin
        am_idx = blk_cnt_q[IDX_W-1:0];
        if (load_ok) begin
          load     = 1'b1;
          sel_am   = 1'b1;
          am_first = (blk_cnt_q == '0);
          if (blk_cnt_q == AM_LAST) begin
            blk_cnt_d = '0;
            state_d   = DATA;
          end else begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        s_ready  = load_ok;
        underrun = load_ok && !s_valid;
        if (s_valid && load_ok) begin
          load = 1'b1;
          if (blk_cnt_q == DATA_LAST) begin
            // Period boundary: the only point where i_enable is sampled.
            last_data_load = 1'b1;
            blk_cnt_d      = '0;
            state_d        = i_enable ? AM : IDLE;
          end else begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        blk_cnt_d = '0;
      end
    endcase
  end

  // State and block-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign o_am_idx  = am_idx;
  assign ld_flow_0 = sel_am ? i_am_flow_0 : s_flow_0;
  assign ld_flow_1 = sel_am ? i_am_flow_1 : s_flow_1;

  aui_out_stage #(
    .BITS_BLOCK (BITS_BLOCK)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .d_flow_0   (ld_flow_0),
    .d_flow_1   (ld_flow_1),
    .d_is_am    (sel_am),
    .d_am_first (am_first),
    .m_ready    (m_ready),
    .load_ok    (load_ok),
    .m_valid    (m_valid),
    .m_flow_0   (m_flow_0),
    .m_flow_1   (m_flow_1),
    .m_is_am    (m_is_am),
    .m_am_first (m_am_first)
  );

`ifdef AUI_AM_STATS_EN
  logic [31:0] period_cnt_q,   period_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Period counter wraps; underrun counter saturates at all-ones.
  always_comb begin
    period_cnt_d   = period_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (last_data_load) begin
      period_cnt_d = period_cnt_q + 32'd1;
    end
    if (underrun && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_q   <= '0;
      underrun_cnt_q <= '0;
    end else begin
      period_cnt_q   <= period_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign o_period_cnt   = period_cnt_q;
  assign o_underrun_cnt = underrun_cnt_q;
`else
  // Without statistics these strobes have no consumer.
  logic unused_stats;
  assign unused_stats = last_data_load ^ underrun;
`endif

endmodule : aui_am_scheduler

// File: tb/tb_aui_am_scheduler.sv
// Directed bench for aui_am_scheduler with DATA_BLOCKS=4 (period of 8).
// Output blocks are checked against an expected queue built from a
// hand-written period model; timing-sensitive points are checked per cycle.
module tb_aui_am_scheduler;

  localparam int BITS  = 257;
  localparam int AMB   = 4;
  localparam int DATB  = 4;
  localparam int EXP_W = 2 + 2 * BITS;

  logic             clk;
  logic             rst;
  logic             i_enable;
  logic             s_valid;
  logic             s_ready;
  logic [BITS-1:0]  s_flow_0;
  logic [BITS-1:0]  s_flow_1;
  logic [1:0]       o_am_idx;
  logic [BITS-1:0]  i_am_flow_0;
  logic [BITS-1:0]  i_am_flow_1;
  logic             m_valid;
  logic             m_ready;
  logic [BITS-1:0]  m_flow_0;
  logic [BITS-1:0]  m_flow_1;
  logic             m_is_am;
  logic             m_am_first;
`ifdef AUI_AM_STATS_EN
  logic [31:0]      o_period_cnt;
  logic [15:0]      o_underrun_cnt;
`endif

  int checks;
  int errors;
  int cyc;
  int drv_seq;
  int exp_seq;
  logic [EXP_W-1:0] exp_q[$];

  logic [1:0] idx_tab [12];
  logic       pat     [7];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- block patterns ----------------
  function automatic logic [BITS-1:0] am_blk(input int idx, input int flow);
    return {1'b1, 224'h0, 8'hA5, 8'(flow), 16'(idx)};
  endfunction

  function automatic logic [BITS-1:0] data_blk(input int seq, input int flow);
    return {1'b0, 208'h0, 16'hDA7A, 8'(flow), 24'(seq)};
  endfunction

  // AM generator model: combinational lookup by index.
  assign i_am_flow_0 = am_blk(int'(o_am_idx), 0);
  assign i_am_flow_1 = am_blk(int'(o_am_idx), 1);

  aui_am_scheduler #(
    .BITS_BLOCK  (BITS),
    .AM_BLOCKS   (AMB),
    .DATA_BLOCKS (DATB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_flow_0    (s_flow_0),
    .s_flow_1    (s_flow_1),
    .o_am_idx    (o_am_idx),
    .i_am_flow_0 (i_am_flow_0),
    .i_am_flow_1 (i_am_flow_1),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_flow_0    (m_flow_0),
    .m_flow_1    (m_flow_1),
    .m_is_am     (m_is_am),
`ifdef AUI_AM_STATS_EN
    .m_am_first  (m_am_first),
    .o_period_cnt   (o_period_cnt),
    .o_underrun_cnt (o_underrun_cnt)
`else
    .m_am_first  (m_am_first)
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [EXP_W-1:0] obs,
                       input logic [EXP_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  task automatic push_am(input int idx);
    exp_q.push_back({1'b1, (idx == 0), am_blk(idx, 1), am_blk(idx, 0)});
  endtask

  task automatic push_data();
    exp_q.push_back({1'b0, 1'b0, data_blk(exp_seq, 1), data_blk(exp_seq, 0)});
    exp_seq++;
  endtask

  task automatic push_period();
    for (int i = 0; i < AMB; i++) push_am(i);
    for (int i = 0; i < DATB; i++) push_data();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_src();
    s_flow_0 = data_blk(drv_seq, 0);
    s_flow_1 = data_blk(drv_seq, 1);
  endtask

  // One clock: score any output transfer, advance, sample #1 after the edge.
  task automatic tick();
    logic in_fire;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {m_is_am, m_am_first, m_flow_1, m_flow_0}, '0);
      end else begin
        check("out_blk", {m_is_am, m_am_first, m_flow_1, m_flow_0}, exp_q.pop_front());
      end
    end
    in_fire = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (in_fire) begin
      drv_seq++;
      drive_src();
    end
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    i_enable = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    exp_seq = drv_seq;
    cyc = 0;
  endtask

  // Let all expected blocks leave, then confirm the scheduler went quiet.
  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    check({tag, "_left"}, exp_q.size(), 0);
    repeat (3) tick();
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_am_idx"}, o_am_idx, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    drv_seq = 0;
    exp_seq = 0;
    idx_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive_src();

    // Reset state
    reset_dut();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_am_idx", o_am_idx, 2'd0);
    check("rst_flow_0", m_flow_0, '0);
    check("rst_flow_1", m_flow_1, '0);
    check("rst_is_am", m_is_am, 1'b0);
    check("rst_am_first", m_am_first, 1'b0);
`ifdef AUI_AM_STATS_EN
    check("rst_period_cnt", o_period_cnt, 32'd0);
    check("rst_underrun_cnt", o_underrun_cnt, 16'd0);
`endif

    // Three gapless periods; enable dropped inside the third.
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    i_enable = 1'b1;
    repeat (3) push_period();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 12) begin
        check("t1_am_idx", o_am_idx, idx_tab[k-1]);
        check("t1_m_valid", m_valid, (k >= 2));
      end
      if (k == 18) i_enable = 1'b0;
`ifdef AUI_AM_STATS_EN
      check("t1_period_cnt", o_period_cnt, int'(k >= 9) + int'(k >= 17) + int'(k >= 25));
`endif
    end
    drain("t1");
`ifdef AUI_AM_STATS_EN
    check("t1_underrun_cnt", o_underrun_cnt, 16'd0);
`endif

    // Backpressure while AM block 2 is held
    reset_dut();
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    i_enable = 1'b1;
    push_period();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) i_enable = 1'b0;
    end
    check("t2_shown_am2", m_flow_0, am_blk(2, 0));
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_valid", m_valid, 1'b1);
      check("t2_hold_flow_0", m_flow_0, am_blk(2, 0));
      check("t2_hold_flow_1", m_flow_1, am_blk(2, 1));
      check("t2_hold_is_am", m_is_am, 1'b1);
      check("t2_hold_am_idx", o_am_idx, 2'd3);
      check("t2_hold_s_ready", s_ready, 1'b0);
    end
    m_ready = 1'b1;
    drain("t2");

    // s_valid gaps during DATA
    reset_dut();
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    i_enable = 1'b1;
    push_period();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) i_enable = 1'b0;
    end
    for (int j = 0; j < 7; j++) begin
      s_valid = pat[j];
      check("t3_s_ready", s_ready, 1'b1);
      tick();
      check("t3_m_valid", m_valid, pat[j]);
    end
    s_valid = 1'b0;
    drain("t3");
`ifdef AUI_AM_STATS_EN
    check("t3_underrun_cnt", o_underrun_cnt, 16'd3);
    check("t3_period_cnt", o_period_cnt, 32'd1);
`endif

    // Enable dropped during data block 1: period completes, then idle
    reset_dut();
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    i_enable = 1'b1;
    push_period();
    for (int k = 1; k <= 6; k++) tick();
    i_enable = 1'b0;
    drain("t4");

    // Reset while AM block 1 is held
    reset_dut();
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    i_enable = 1'b1;
    push_am(0);
    for (int k = 1; k <= 3; k++) tick();
    check("t5_shown_am1", m_flow_0, am_blk(1, 0));
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_m_valid", m_valid, 1'b0);
    check("t5_rst_s_ready", s_ready, 1'b0);
    check("t5_rst_am_idx", o_am_idx, 2'd0);
    check("t5_rst_left", exp_q.size(), 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    exp_seq = drv_seq;
    cyc     = 0;
    push_period();
    tick();
    i_enable = 1'b0;
    tick();
    check("t5_restart_valid", m_valid, 1'b1);
    check("t5_restart_first", m_am_first, 1'b1);
    check("t5_restart_flow_0", m_flow_0, am_blk(0, 0));
    drain("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_aui_am_scheduler

// File: doc/aui_am_scheduler.md
Name: aui_am_scheduler

Overview:
- Sequences alignment-marker (AM) insertion into the two-flow 257-bit block stream of the AUI transmit path.
- Each period emits AM_BLOCKS marker blocks, fetched by index from the AM generator, then DATA_BLOCKS upstream scrambled blocks.
- Applies backpressure upstream during marker insertion.
- Sits between the scrambler output and the FEC/distribution stage.

Parameters:
- BITS_BLOCK, 257, width of one block per flow.
- AM_BLOCKS, 4, marker blocks per period (1028 AM bits / 257).
- DATA_BLOCKS, 36, upstream data blocks per period. Period = AM_BLOCKS + DATA_BLOCKS = 40.
- CNT_W, $clog2(DATA_BLOCKS+1), block counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  start/continue AM-periodic operation.
- s_valid  in  1  upstream block pair valid.
- s_ready  out  1  upstream accept.
- s_flow_0  in  BITS_BLOCK  upstream flow 0 block.
- s_flow_1  in  BITS_BLOCK  upstream flow 1 block.
- o_am_idx  out  $clog2(AM_BLOCKS)  index of the AM block requested from the generator.
- i_am_flow_0  in  BITS_BLOCK  generator flow 0 block at o_am_idx (combinational).
- i_am_flow_1  in  BITS_BLOCK  generator flow 1 block at o_am_idx (combinational).
- m_valid  out  1  output block pair valid.
- m_ready  in  1  downstream accept.
- m_flow_0  out  BITS_BLOCK  output flow 0 block.
- m_flow_1  out  BITS_BLOCK  output flow 1 block.
- m_is_am  out  1  current output is an AM block.
- m_am_first  out  1  current output is AM block 0, marking the start of a period.

Behaviour:
- Single registered output stage. load_ok = !m_valid || m_ready.
- Latency: 1 cycle from the load decision to the data appearing on m_*.
- While m_valid && !m_ready, all m_* outputs are held stable.
- FSM states:
  - IDLE: s_ready=0, no loads. When i_enable=1, go to AM with blk_cnt=0.
  - AM: s_ready=0; o_am_idx=blk_cnt. On load_ok, load i_am_flow_*, set m_is_am=1, set m_am_first=(blk_cnt==0), increment blk_cnt. When the block loaded is AM_BLOCKS-1, clear blk_cnt and go to DATA.
  - DATA: s_ready=load_ok. On s_valid&&s_ready, load s_flow_*, set m_is_am=0, increment blk_cnt. When the block loaded is DATA_BLOCKS-1, clear blk_cnt; then if i_enable=1 go to AM, otherwise go to IDLE.
- If s_valid=0 in DATA, nothing is loaded. m_valid drops once the output drains; no filler blocks are inserted and the period count does not advance.
- If i_enable falls mid-period, it is ignored until the period boundary. The period always completes.
- When idle, m_valid clears once the held block is accepted.
- o_am_idx is 0 in IDLE and DATA.
- Reset values: state=IDLE, blk_cnt=0, m_valid=0, m_flow_*=0, m_is_am=0, m_am_first=0, s_ready=0, o_am_idx=0.
- Reset mid-period drops any held output, and the next enable starts a fresh period at AM block 0.
- Counter arithmetic is unsigned CNT_W; comparisons are against parameter-1 constants. No wrap beyond the period length.

Optional Feature:
- Macro: AUI_AM_STATS_EN.
- When defined, adds two outputs:
  - o_period_cnt (32 bits): counts completed periods (last data block loaded). Wraps at 2^32.
  - o_underrun_cnt (16 bits): saturating count of cycles in DATA with load_ok=1 and s_valid=0.
  - Both are reset to 0.
- When undefined, these ports and their logic are absent, and the behaviour of all other ports is identical.

Decomposition:
- Package aui_pkg holds:
  - AUI_BITS_BLOCK=257, AUI_AM_BLOCKS=4, AUI_DATA_BLOCKS=36.
  - typedef aui_block_t (logic [256:0]).
  - enum aui_sched_state_e {IDLE, AM, DATA}.
- One natural sub-module: aui_out_stage. It is the valid/ready output register holding the two flows plus the is_am/am_first tags, with a load strobe input.

Test Plan:
- Reset, then i_enable=1, s_valid=1, m_ready=1, with DATA_BLOCKS=4. Required output: 4 AM blocks with m_is_am=1, o_am_idx sequence 0,1,2,3, and m_am_first only on the first; then 4 data blocks; then a repeat. No gaps, and the first m_valid appears 2 cycles after enable.
- m_ready low for 3 cycles while AM block 2 is held. m_flow_*, m_is_am and o_am_idx must stay stable. Then AM block 3, then data, with no block lost or duplicated.
- s_valid toggling 1/0 in DATA. Exactly DATA_BLOCKS data blocks are output between AM groups, with gaps where s_valid=0. With stats enabled, o_underrun_cnt equals the number of zero cycles.
- i_enable dropped during data block 1 of 4. Data blocks 2 and 3 are still output, then the FSM goes to IDLE with no AM block; m_valid=0 after drain.
- rst asserted while AM block 1 is held with m_ready=0. Next cycle: m_valid=0, s_ready=0, o_am_idx=0. After re-enable the sequence restarts at AM block 0 with m_am_first=1.
- With AUI_AM_STATS_EN, run 3 full periods. o_period_cnt=3, and it increments on the cycle the last data block is loaded.
